// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int DEF_TICK_DIV   = 5000;
    localparam int DEF_STABLE_CNT = 4;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button-side bundle of the debouncer: raw inputs, enable, debounced outputs and tick.
interface debounce_multi_if #(parameter int N_CH = 4);

    logic            enable;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic            tick;

    modport master (output enable, output btn_in,
                    input btn_level, input btn_rise, input btn_fall, input tick);
    modport slave  (input enable, input btn_in,
                    output btn_level, output btn_rise, output btn_fall, output tick);

endinterface

// File: rtl/debounce_cell.sv
// One channel: 2-flop synchroniser, consecutive-sample counter, level register and edge strobes.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    parameter logic RST_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic tick,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2_min1(STABLE_CNT);

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;

    assign s = sync[1];

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync  <= {2{RST_LEVEL}};
            cnt   <= '0;
            level <= RST_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], btn_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                // Any sample matching the current level throws away the run.
                if (s == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(STABLE_CNT - 1)) begin
                    level <= s;
                    cnt   <= '0;
                    rise  <= s;
                    fall  <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Shared sample-tick prescaler feeding N_CH independent debounce cells.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   N_CH       = 4,
    parameter int   TICK_DIV   = DEF_TICK_DIV,
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    parameter logic RST_LEVEL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_a_p,
    debounce_multi_if.slave bus
);

    localparam int TW = clog2_min1(TICK_DIV);

    logic [TW-1:0]   count;
    logic            tick_q;
    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;

    // Count holds while disabled so a resume continues mid-period with no extra tick.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (bus.enable) begin
            if (int'(count) >= TICK_DIV - 1) begin
                count  <= '0;
                tick_q <= 1'b1;
            end else begin
                count  <= count + 1'b1;
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_cell #(
            .STABLE_CNT(STABLE_CNT),
            .RST_LEVEL (RST_LEVEL)
        ) u_cell (
            .clk    (clk),
            .rst_a_p(rst_a_p),
            .tick   (tick_q),
            .btn_in (bus.btn_in[gi]),
            .level  (level_w[gi]),
            .rise   (rise_w[gi]),
            .fall   (fall_w[gi])
        );
    end

    assign bus.tick      = tick_q;
    assign bus.btn_level = level_w;
    assign bus.btn_rise  = rise_w;
    assign bus.btn_fall  = fall_w;

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised bench for debounce_multi against a cycle-level behavioural reference.
module tb_debounce_multi;

    localparam int NC = 2;
    localparam int TD = 4;
    localparam int SC = 3;

    logic clk = 1'b0;
    logic rst_a_p;
    int   n_chk = 0;
    int   n_fail = 0;
    logic saw_simul = 1'b0;

    debounce_multi_if #(.N_CH(NC)) bus ();

    debounce_multi #(
        .N_CH(NC), .TICK_DIV(TD), .STABLE_CNT(SC), .RST_LEVEL(1'b0)
    ) dut (
        .clk    (clk),
        .rst_a_p(rst_a_p),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: ticks fall on every TD-th enabled edge since reset; a level flips
    // once SC tick samples in a row have disagreed with it.
    logic          m_tick;
    int            m_en;
    logic [NC-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    int            m_run [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tick = 1'b0; m_en = 0;
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < NC; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic e, input logic [NC-1:0] b);
        logic [NC-1:0] samp;
        logic          t;
        samp = m_s2;
        t    = m_tick;
        m_rise = '0;
        m_fall = '0;
        if (t) begin
            for (int i = 0; i < NC; i++) begin
                if (samp[i] == m_lvl[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == SC) begin
                        m_lvl[i] = samp[i];
                        m_run[i] = 0;
                        if (samp[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
        if (e) begin
            m_en++;
            m_tick = (m_en % TD) == 0;
        end else begin
            m_tick = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("tick",  32'(bus.tick),      32'(m_tick));
        chk("level", 32'(bus.btn_level), 32'(m_lvl));
        chk("rise",  32'(bus.btn_rise),  32'(m_rise));
        chk("fall",  32'(bus.btn_fall),  32'(m_fall));
        if (bus.btn_rise[0] && bus.btn_fall[1]) saw_simul = 1'b1;
    endtask

    // Entered and left on a negedge.
    task automatic cyc(input logic e, input logic [NC-1:0] b);
        bus.enable = e;
        bus.btn_in = b;
        @(posedge clk);
        model_step(e, b);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_a_p = 1'b1;
        #1;
        model_reset();
        chk("rst_tick",  32'(bus.tick),      32'd0);
        chk("rst_level", 32'(bus.btn_level), 32'd0);
        chk("rst_rise",  32'(bus.btn_rise),  32'd0);
        chk("rst_fall",  32'(bus.btn_fall),  32'd0);
        @(negedge clk);
        rst_a_p = 1'b0;
    endtask

    initial begin
        logic [NC-1:0] b;
        logic          e;
        rst_a_p    = 1'b0;
        bus.enable = 1'b0;
        bus.btn_in = '0;
        @(negedge clk);
        do_reset();

        // Channel 1 to 1, then both channels flip together.
        for (int k = 0; k < 24; k++) cyc(1'b1, 2'b10);
        chk("ch1_high", 32'(bus.btn_level), 32'h2);
        for (int k = 0; k < 24; k++) cyc(1'b1, 2'b01);
        chk("simul", 32'(saw_simul), 32'd1);
        chk("swap_level", 32'(bus.btn_level), 32'h1);

        // Reset after two differing ticks, then a fresh acceptance must take the full count.
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1'b1, 2'b11);
        do_reset();
        for (int k = 0; k < 14; k++) cyc(1'b1, 2'b11);

        b = '0;
        e = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 15) == 0) b[i] = ~b[i];
            if (e && $urandom_range(0, 39) == 0) e = 1'b0;
            else if (!e && $urandom_range(0, 7) == 0) e = 1'b1;
            if ($urandom_range(0, 699) == 0) do_reset();
            else cyc(e, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
